lsp_dequant: RTL

Decoder-side scalar LSP dequantizer for the CODEC2_DECODE_2400 path. It is the inverse of the encoder's codebook selection: it takes the 36-bit packed LSP index field and looks up each of the 10 indices in the matching codebook (codes0..codes9). It then streams the 10 LSP frequencies in Hz, in 1-15-16 fixed point, over a valid/ready interface. It also flags frames whose decoded LSPs are not strictly ascending.

---
 rtl/lsp_dequant.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lsp_dequant.sv
// Scalar LSP dequantizer: unpacks ten codebook indices, looks each one up and
// streams the LSP frequencies (1-15-16 fixed point) over valid/ready, flagging
// frames whose LSPs are not strictly ascending.
module lsp_dequant #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [35:0]   indexes,
  input  logic          out_ready,
  output logic [N-1:0]  lsp_hz,
  output logic [3:0]    lsp_num,
  output logic          lsp_valid,
  output logic          order_err,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [35:0]   shadow_q, shadow_d;
  logic [N-1:0]  lsp_hz_q, lsp_hz_d;
  logic [3:0]    lsp_num_q, lsp_num_d;
  logic          lsp_valid_q, lsp_valid_d;
  logic          order_err_q, order_err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  code;

  // Extract the index field of LSP k; narrower fields are zero-extended.
  function automatic logic [3:0] field(input logic [35:0] idx, input logic [3:0] k);
    logic [3:0] f;
    case (k)
      4'd0:    f = idx[3:0];
      4'd1:    f = idx[7:4];
      4'd2:    f = idx[11:8];
      4'd3:    f = idx[15:12];
      4'd4:    f = idx[19:16];
      4'd5:    f = idx[23:20];
      4'd6:    f = idx[27:24];
      4'd7:    f = {1'b0, idx[30:28]};
      4'd8:    f = {1'b0, idx[33:31]};
      4'd9:    f = {2'b00, idx[35:34]};
      default: f = 4'd0;
    endcase
    return f;
  endfunction

  // Codebook lookup. Every Codec2 scalar LSP table is a uniform grid, so each
  // table is stored as (first entry, spacing) in Hz and scaled by 65536.
  function automatic logic [N-1:0] codebook(input logic [3:0] k, input logic [3:0] a);
    logic [15:0] base;
    logic [15:0] step;
    logic [15:0] hz;
    case (k)
      4'd0:    begin base = 16'd225;  step = 16'd25;  end
      4'd1:    begin base = 16'd325;  step = 16'd25;  end
      4'd2:    begin base = 16'd500;  step = 16'd50;  end
      4'd3:    begin base = 16'd700;  step = 16'd100; end
      4'd4:    begin base = 16'd950;  step = 16'd100; end
      4'd5:    begin base = 16'd1100; step = 16'd100; end
      4'd6:    begin base = 16'd1500; step = 16'd100; end
      4'd7:    begin base = 16'd2300; step = 16'd100; end
      4'd8:    begin base = 16'd2500; step = 16'd100; end
      4'd9:    begin base = 16'd2900; step = 16'd200; end
      default: begin base = 16'd0;    step = 16'd0;   end
    endcase
    hz = base + step * {12'd0, a};
    return {{(N-16){1'b0}}, hz} << 16;
  endfunction

  // Next-state logic: frame sequencing, LSP loading and order checking.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    lsp_hz_d    = lsp_hz_q;
    lsp_num_d   = lsp_num_q;
    lsp_valid_d = lsp_valid_q;
    order_err_d = order_err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    code        = codebook(count_q, field(shadow_q, count_q));
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d    = indexes;
          count_d     = 4'd0;
          order_err_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!lsp_valid_q || out_ready) begin
          if (count_q <= 4'd9) begin
            lsp_hz_d    = code;
            lsp_num_d   = count_q;
            lsp_valid_d = 1'b1;
            count_d     = count_q + 4'd1;
            // lsp_hz_q still holds the previously loaded LSP here
            if (count_q != 4'd0 && code <= lsp_hz_q) order_err_d = 1'b1;
          end else if (out_ready) begin
            lsp_valid_d = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset of every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      shadow_q    <= 36'd0;
      lsp_hz_q    <= '0;
      lsp_num_q   <= 4'd0;
      lsp_valid_q <= 1'b0;
      order_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      lsp_hz_q    <= lsp_hz_d;
      lsp_num_q   <= lsp_num_d;
      lsp_valid_q <= lsp_valid_d;
      order_err_q <= order_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lsp_hz    = lsp_hz_q;
  assign lsp_num   = lsp_num_q;
  assign lsp_valid = lsp_valid_q;
  assign order_err = order_err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
